// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. It inserts bubbles for load-use and JR-after-DM-producer hazards,
// holds on memory freeze and kills on branch redirect.
module id_ex_stage #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [ADDR_W-1:0]  id_rs_addr,
  input  logic [ADDR_W-1:0]  id_rt_addr,
  input  logic [ADDR_W-1:0]  id_dst_addr,
  input  logic               id_uses_rs,
  input  logic               id_uses_rt,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               id_memwrite,
  input  logic               id_jr,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic [ADDR_W-1:0]  WB_dst_addr_EX_DM,
  input  logic               WB_RegWrite_EX_DM,
  input  logic               flush_ex,
  input  logic               dm_stall,
  output logic [ADDR_W-1:0]  EX_Rs_Addr_ID_EX,
  output logic [ADDR_W-1:0]  EX_Rt_Addr_ID_EX,
  output logic [ADDR_W-1:0]  EX_dst_addr_ID_EX,
  output logic [DATA_W-1:0]  EX_rs_data,
  output logic [DATA_W-1:0]  EX_rt_data,
  output logic [DATA_W-1:0]  EX_imm,
  output logic               EX_RegWrite,
  output logic               EX_MemRead,
  output logic               EX_MemWrite,
  output logic               EX_valid,
  output logic [ALUOP_W-1:0] EX_alu_op,
  output logic               stall_if_id,
  output logic [CNT_W-1:0]   stall_count
);

  logic rs_match;
  logic rt_match;
  logic lu_haz;
  logic jd_haz;
  logic haz;
  logic bubble;
  logic capture;

  // JR target forwarding only reaches back to EX, so a producer sitting in DM must stall.
  always_comb begin
    rs_match = id_uses_rs && (id_rs_addr == EX_dst_addr_ID_EX);
    rt_match = id_uses_rt && (id_rt_addr == EX_dst_addr_ID_EX);
    lu_haz   = id_valid && EX_valid && EX_MemRead &&
               (EX_dst_addr_ID_EX != '0) && (rs_match || rt_match);
    jd_haz   = id_valid && id_jr && WB_RegWrite_EX_DM &&
               (WB_dst_addr_EX_DM != '0) && (WB_dst_addr_EX_DM == id_rs_addr);
    haz      = lu_haz || jd_haz;
    bubble   = !dm_stall && (flush_ex || haz);
    capture  = !dm_stall && !flush_ex && !haz;
  end

  assign stall_if_id = haz && !flush_ex && !dm_stall && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      EX_valid          <= 1'b0;
      EX_RegWrite       <= 1'b0;
      EX_MemRead        <= 1'b0;
      EX_MemWrite       <= 1'b0;
      EX_alu_op         <= '0;
      EX_Rs_Addr_ID_EX  <= '0;
      EX_Rt_Addr_ID_EX  <= '0;
      EX_dst_addr_ID_EX <= '0;
    end else if (bubble || (capture && !id_valid)) begin
      EX_valid          <= 1'b0;
      EX_RegWrite       <= 1'b0;
      EX_MemRead        <= 1'b0;
      EX_MemWrite       <= 1'b0;
      EX_alu_op         <= '0;
      EX_Rs_Addr_ID_EX  <= '0;
      EX_Rt_Addr_ID_EX  <= '0;
      EX_dst_addr_ID_EX <= '0;
    end else if (capture) begin
      EX_valid          <= 1'b1;
      EX_RegWrite       <= id_regwrite;
      EX_MemRead        <= id_memread;
      EX_MemWrite       <= id_memwrite;
      EX_alu_op         <= id_alu_op;
      EX_Rs_Addr_ID_EX  <= id_rs_addr;
      EX_Rt_Addr_ID_EX  <= id_rt_addr;
      EX_dst_addr_ID_EX <= id_dst_addr;
    end
  end

  // Operand data is don't-care inside a bubble, so it simply holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      EX_rs_data <= '0;
      EX_rt_data <= '0;
      EX_imm     <= '0;
    end else if (capture) begin
      EX_rs_data <= id_rs_data;
      EX_rt_data <= id_rt_data;
      EX_imm     <= id_imm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (!dm_stall && !flush_ex && haz && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboarded bench for id_ex_stage: a model of "which instruction occupies EX" predicts
// every cycle's stall and registered outputs; a 4-bit-counter instance covers saturation.
module tb_id_ex_stage;

  typedef struct {
    logic        valid;
    logic [3:0]  rs, rt, dst;
    logic        urs, urt;
    logic [15:0] rsd, rtd, imm;
    logic        rw, mr, mw, jr;
    logic [3:0]  op;
    logic [3:0]  wbd;
    logic        wbrw;
    logic        flush, dms;
  } stim_t;

  typedef struct {
    logic        valid;
    logic [3:0]  rs, rt, dst;
    logic [15:0] rsd, rtd, imm;
    logic        rw, mr, mw;
    logic [3:0]  op;
  } ex_t;

  typedef struct {
    logic stall;
    ex_t  ex;
    int   c16;
    int   c4;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0;
  logic [3:0] id_rs_addr = '0, id_rt_addr = '0, id_dst_addr = '0;
  logic id_uses_rs = 1'b0, id_uses_rt = 1'b0;
  logic [15:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
  logic id_regwrite = 1'b0, id_memread = 1'b0, id_memwrite = 1'b0, id_jr = 1'b0;
  logic [3:0] id_alu_op = '0;
  logic [3:0] WB_dst_addr_EX_DM = '0;
  logic WB_RegWrite_EX_DM = 1'b0;
  logic flush_ex = 1'b0, dm_stall = 1'b0;

  logic [3:0]  EX_Rs_Addr_ID_EX, EX_Rt_Addr_ID_EX, EX_dst_addr_ID_EX;
  logic [15:0] EX_rs_data, EX_rt_data, EX_imm;
  logic        EX_RegWrite, EX_MemRead, EX_MemWrite, EX_valid;
  logic [3:0]  EX_alu_op;
  logic        stall_if_id;
  logic [15:0] stall_count;

  logic [3:0]  s_rs, s_rt, s_dst;
  logic [15:0] s_rsd, s_rtd, s_imm;
  logic        s_rw, s_mr, s_mw, s_valid;
  logic [3:0]  s_op;
  logic        s_stall;
  logic [3:0]  s_count;

  int total = 0;
  int bad = 0;
  exp_t q[$];
  ex_t exM;
  int cnt16M, cnt4M;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_dst_addr(id_dst_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_jr(id_jr), .id_alu_op(id_alu_op),
    .WB_dst_addr_EX_DM(WB_dst_addr_EX_DM), .WB_RegWrite_EX_DM(WB_RegWrite_EX_DM),
    .flush_ex(flush_ex), .dm_stall(dm_stall),
    .EX_Rs_Addr_ID_EX(EX_Rs_Addr_ID_EX), .EX_Rt_Addr_ID_EX(EX_Rt_Addr_ID_EX),
    .EX_dst_addr_ID_EX(EX_dst_addr_ID_EX),
    .EX_rs_data(EX_rs_data), .EX_rt_data(EX_rt_data), .EX_imm(EX_imm),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_valid(EX_valid), .EX_alu_op(EX_alu_op),
    .stall_if_id(stall_if_id), .stall_count(stall_count)
  );

  id_ex_stage #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_dst_addr(id_dst_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_jr(id_jr), .id_alu_op(id_alu_op),
    .WB_dst_addr_EX_DM(WB_dst_addr_EX_DM), .WB_RegWrite_EX_DM(WB_RegWrite_EX_DM),
    .flush_ex(flush_ex), .dm_stall(dm_stall),
    .EX_Rs_Addr_ID_EX(s_rs), .EX_Rt_Addr_ID_EX(s_rt), .EX_dst_addr_ID_EX(s_dst),
    .EX_rs_data(s_rsd), .EX_rt_data(s_rtd), .EX_imm(s_imm),
    .EX_RegWrite(s_rw), .EX_MemRead(s_mr), .EX_MemWrite(s_mw),
    .EX_valid(s_valid), .EX_alu_op(s_op),
    .stall_if_id(s_stall), .stall_count(s_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkEx(input exp_t e);
    checkOutput("EX_valid", {31'd0, EX_valid}, {31'd0, e.ex.valid});
    checkOutput("EX_RegWrite", {31'd0, EX_RegWrite}, {31'd0, e.ex.rw});
    checkOutput("EX_MemRead", {31'd0, EX_MemRead}, {31'd0, e.ex.mr});
    checkOutput("EX_MemWrite", {31'd0, EX_MemWrite}, {31'd0, e.ex.mw});
    checkOutput("EX_alu_op", {28'd0, EX_alu_op}, {28'd0, e.ex.op});
    checkOutput("EX_rs_addr", {28'd0, EX_Rs_Addr_ID_EX}, {28'd0, e.ex.rs});
    checkOutput("EX_rt_addr", {28'd0, EX_Rt_Addr_ID_EX}, {28'd0, e.ex.rt});
    checkOutput("EX_dst_addr", {28'd0, EX_dst_addr_ID_EX}, {28'd0, e.ex.dst});
    if (e.ex.valid) begin
      checkOutput("EX_rs_data", {16'd0, EX_rs_data}, {16'd0, e.ex.rsd});
      checkOutput("EX_rt_data", {16'd0, EX_rt_data}, {16'd0, e.ex.rtd});
      checkOutput("EX_imm", {16'd0, EX_imm}, {16'd0, e.ex.imm});
    end
    checkOutput("stall_count", {16'd0, stall_count}, e.c16);
    checkOutput("stall_count_w4", {28'd0, s_count}, e.c4);
  endtask

  // Model: the instruction now in EX is a load whose result the ID instruction needs,
  // or a JR whose target register is still being produced by the instruction in DM.
  function automatic logic modelHazard(input stim_t s);
    logic needsLoad, needsDm;
    needsLoad = s.valid && exM.valid && exM.mr && exM.dst != 0 &&
                ((s.urs && s.rs == exM.dst) || (s.urt && s.rt == exM.dst));
    needsDm   = s.valid && s.jr && s.wbrw && s.wbd != 0 && s.wbd == s.rs;
    return needsLoad || needsDm;
  endfunction

  // Caller sits just after a rising edge; drives one cycle and returns just after the next edge.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    logic h;
    id_valid = s.valid; id_rs_addr = s.rs; id_rt_addr = s.rt; id_dst_addr = s.dst;
    id_uses_rs = s.urs; id_uses_rt = s.urt;
    id_rs_data = s.rsd; id_rt_data = s.rtd; id_imm = s.imm;
    id_regwrite = s.rw; id_memread = s.mr; id_memwrite = s.mw; id_jr = s.jr;
    id_alu_op = s.op; WB_dst_addr_EX_DM = s.wbd; WB_RegWrite_EX_DM = s.wbrw;
    flush_ex = s.flush; dm_stall = s.dms;
    h = modelHazard(s);
    e.stall = h && !s.flush && !s.dms;
    if (!s.dms) begin
      if (s.flush || h || !s.valid) begin
        exM.valid = 0; exM.rw = 0; exM.mr = 0; exM.mw = 0; exM.op = 0;
        exM.rs = 0; exM.rt = 0; exM.dst = 0;
        if (h && !s.flush) begin
          if (cnt16M < 65535) cnt16M++;
          if (cnt4M < 15) cnt4M++;
        end
      end else begin
        exM.valid = 1; exM.rw = s.rw; exM.mr = s.mr; exM.mw = s.mw; exM.op = s.op;
        exM.rs = s.rs; exM.rt = s.rt; exM.dst = s.dst;
        exM.rsd = s.rsd; exM.rtd = s.rtd; exM.imm = s.imm;
      end
    end
    e.ex = exM; e.c16 = cnt16M; e.c4 = cnt4M;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t instr(input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] dst,
                                  input logic urs, input logic urt, input logic rw,
                                  input logic mr, input logic jr);
    stim_t s;
    s.valid = 1; s.rs = rs; s.rt = rt; s.dst = dst; s.urs = urs; s.urt = urt;
    s.rsd = 16'($urandom); s.rtd = 16'($urandom); s.imm = 16'($urandom);
    s.rw = rw; s.mr = mr; s.mw = 0; s.jr = jr; s.op = 4'($urandom_range(15, 1));
    s.wbd = 0; s.wbrw = 0; s.flush = 0; s.dms = 0;
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s = instr(4'($urandom_range(3, 0)), 4'($urandom_range(3, 0)), 4'($urandom_range(3, 0)),
              1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(2, 0) == 0),
              ($urandom_range(5, 0) == 0));
    s.valid = ($urandom_range(7, 0) != 0);
    s.mw    = 1'($urandom);
    s.wbd   = 4'($urandom_range(3, 0));
    s.wbrw  = 1'($urandom);
    s.flush = ($urandom_range(9, 0) == 0);
    s.dms   = ($urandom_range(7, 0) == 0);
    return s;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, {31'd0, EX_valid}, 0);
    checkOutput({tag, "_ctrl"}, {29'd0, EX_RegWrite, EX_MemRead, EX_MemWrite}, 0);
    checkOutput({tag, "_addr"}, {20'd0, EX_Rs_Addr_ID_EX, EX_Rt_Addr_ID_EX, EX_dst_addr_ID_EX}, 0);
    checkOutput({tag, "_op"}, {28'd0, EX_alu_op}, 0);
    checkOutput({tag, "_data"}, {EX_rs_data, EX_rt_data | EX_imm}, 0);
    checkOutput({tag, "_count"}, {12'd0, stall_count | {12'd0, s_count}}, 0);
    checkOutput({tag, "_stall"}, {31'd0, stall_if_id}, 0);
  endtask

  // Monitor: each queued expectation covers one cycle's stall and the state after its edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checkOutput("stall_if_id", {31'd0, stall_if_id}, {31'd0, e.stall});
        @(posedge clk);
        #2;
        checkEx(e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    stim_t s;
    exM = '{default: '0};
    cnt16M = 0; cnt4M = 0;
    #12;
    checkAllZero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] load-use r3");
    applyStimulus(instr(4'd1, 4'd2, 4'd3, 1, 1, 1, 1, 0));
    s = instr(4'd3, 4'd1, 4'd6, 1, 0, 1, 0, 0);
    applyStimulus(s);
    applyStimulus(s);

    $display("[TB] jr on load r5");
    applyStimulus(instr(4'd1, 4'd2, 4'd5, 1, 0, 1, 1, 0));
    s = instr(4'd5, 4'd0, 4'd0, 1, 0, 0, 0, 1);
    applyStimulus(s);
    s.wbd = 4'd5; s.wbrw = 1;
    applyStimulus(s);
    s.wbd = 4'd0; s.wbrw = 0;
    applyStimulus(s);

    $display("[TB] no false hazards");
    applyStimulus(instr(4'd1, 4'd2, 4'd0, 1, 0, 1, 1, 0));
    applyStimulus(instr(4'd0, 4'd0, 4'd7, 1, 1, 1, 0, 0));
    applyStimulus(instr(4'd1, 4'd2, 4'd4, 1, 1, 1, 0, 0));
    applyStimulus(instr(4'd4, 4'd4, 4'd7, 1, 1, 1, 0, 0));
    applyStimulus(instr(4'd1, 4'd2, 4'd6, 1, 1, 1, 1, 0));
    applyStimulus(instr(4'd1, 4'd6, 4'd7, 1, 0, 1, 0, 0));

    $display("[TB] priority freeze and flush");
    applyStimulus(instr(4'd1, 4'd2, 4'd3, 1, 1, 1, 1, 0));
    s = instr(4'd3, 4'd3, 4'd5, 1, 1, 1, 0, 0);
    s.flush = 1; s.dms = 1;
    applyStimulus(s);
    s.dms = 0;
    applyStimulus(s);
    s.flush = 0;
    applyStimulus(s);

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(instr(4'd1, 4'd2, 4'd7, 0, 0, 1, 0, 0));
    #3;
    s = instr(4'd2, 4'd0, 4'd0, 1, 0, 0, 0, 1);
    s.wbd = 4'd2; s.wbrw = 1;
    id_valid = 1; id_jr = 1; id_rs_addr = 4'd2; id_uses_rs = 1;
    WB_dst_addr_EX_DM = 4'd2; WB_RegWrite_EX_DM = 1; flush_ex = 0; dm_stall = 0;
    rst = 1'b1;
    #1;
    checkAllZero("midreset");
    @(posedge clk); #1;
    checkAllZero("heldreset");
    rst = 1'b0;
    exM = '{default: '0};
    cnt16M = 0; cnt4M = 0;

    $display("[TB] saturation");
    for (int i = 0; i < 20; i++) applyStimulus(s);
    applyStimulus(instr(4'd1, 4'd1, 4'd1, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    checkOutput("sat_count_w4", {28'd0, s_count}, 15);
    checkOutput("sat_count_w16", {16'd0, stall_count}, 20);
    @(posedge clk); #1;

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) applyStimulus(randStim());
    repeat (3) @(posedge clk);
    checkOutput("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
